// File: rtl/demux_1_32_pkg.sv
// Shared constants and state encoding for the 1:32 write demux and its 32:1 read mux partner.
package demux_1_32_pkg;

    localparam int DMX_WIDTH     = 16;
    localparam int DMX_ADDR_BITS = 5;
    localparam int DMX_DEPTH     = 1 << DMX_ADDR_BITS;

    // One-hot encoding keeps the two unused codes distinct so they can be caught and recovered.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

endpackage

// File: rtl/decoder_5_32.sv
// Combinational binary-to-one-hot decoder; shared by the write path and the clear sweep.
module decoder_5_32
    import demux_1_32_pkg::*;
#(
    parameter int ADDR_BITS = DMX_ADDR_BITS
) (
    input  logic [ADDR_BITS-1:0]      i_addr,
    output logic [(1<<ADDR_BITS)-1:0] o_onehot
);

    // NOTE: default every combinational output before the conditional assignment so no latch is inferred.
    always_comb begin
        o_onehot         = '0;
        o_onehot[i_addr] = 1'b1;
    end

endmodule

// File: rtl/demux_1_32.sv
// 1:32 write demux: handshaked writes into 32 registered words, plus a one-word-per-cycle clear sweep.
module demux_1_32
    import demux_1_32_pkg::*;
#(
    parameter int WIDTH     = DMX_WIDTH,
    parameter int ADDR_BITS = DMX_ADDR_BITS,
    localparam int DEPTH    = 1 << ADDR_BITS
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   WrValid,
    output logic                   WrReady,
    input  logic [ADDR_BITS-1:0]   WrAddr,
    input  logic [WIDTH-1:0]       WrData,
    input  logic                   ClrReq,
    output logic                   Busy,
    output logic [DEPTH-1:0]       Strobe,
    output logic [DEPTH*WIDTH-1:0] Q
);

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_BITS-1:0]  r_count;
    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH-1:0]      r_strobe;

    logic                  w_idle;
    logic                  w_clearing;
    logic                  w_accept;
    logic                  w_update;
    logic [ADDR_BITS-1:0]  w_dec_addr;
    logic [DEPTH-1:0]      w_onehot;
    logic [WIDTH-1:0]      w_wr_data;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_clearing = (r_state == ST_CLEAR);
    assign WrReady    = w_idle && !ClrReq;
    assign Busy       = w_clearing;
    assign w_accept   = WrValid && WrReady;
    assign w_update   = w_accept || w_clearing;
    assign w_dec_addr = w_clearing ? r_count : WrAddr;
    assign w_wr_data  = w_clearing ? '0 : WrData;

    decoder_5_32 #(.ADDR_BITS(ADDR_BITS)) u_decoder (
        .i_addr   (w_dec_addr),
        .o_onehot (w_onehot)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (ClrReq) w_state_next = ST_CLEAR;
            ST_CLEAR: if (&r_count) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_strobe <= '0;
        end else begin
            r_state  <= w_state_next;
            r_strobe <= w_update ? w_onehot : '0;
            if (w_clearing) r_count <= r_count + 1'b1;
        end
    end

    // NOTE: the word array is flops, not RAM, because reset must zero every word asynchronously.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_update && w_onehot[i]) r_mem[i] <= w_wr_data;
            end
        end
    end

    assign Strobe = r_strobe;

    for (genvar g = 0; g < DEPTH; g++) begin : g_q
        assign Q[g*WIDTH +: WIDTH] = r_mem[g];
    end

endmodule

// File: tb/tb_demux_1_32.sv
// Directed bench for demux_1_32 with a reference model feeding a per-cycle expectation queue.
module tb_demux_1_32;

    logic          Clk;
    logic          Reset;
    logic          WrValid;
    logic          WrReady;
    logic [4:0]    WrAddr;
    logic [15:0]   WrData;
    logic          ClrReq;
    logic          Busy;
    logic [31:0]   Strobe;
    logic [511:0]  Q;

    demux_1_32 dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .WrValid (WrValid),
        .WrReady (WrReady),
        .WrAddr  (WrAddr),
        .WrData  (WrData),
        .ClrReq  (ClrReq),
        .Busy    (Busy),
        .Strobe  (Strobe),
        .Q       (Q)
    );

    typedef struct {
        string        tag;
        logic [31:0]  strobe;
        logic [511:0] q;
        logic         busy;
    } exp_t;

    exp_t         sb [$];
    int           n_cmp = 0;
    int           n_mis = 0;

    logic [511:0] m_q;
    logic         m_busy;
    logic [4:0]   m_cnt;
    int           busy_cycles;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q    = '0;
        m_busy = 1'b0;
        m_cnt  = '0;
    endtask

    // Drive one cycle at the falling edge, predict the post-edge state, compare after the rising edge.
    task automatic cycle(input string tag, input logic v, input logic [4:0] a,
                         input logic [15:0] d, input logic c);
        exp_t e;
        exp_t got;
        @(negedge Clk);
        WrValid = v;
        WrAddr  = a;
        WrData  = d;
        ClrReq  = c;
        #1;
        check({tag, ".ready"}, 512'(WrReady), 512'(!m_busy && !c));
        e.tag    = tag;
        e.strobe = '0;
        if (m_busy) begin
            m_q[m_cnt*16 +: 16] = '0;
            e.strobe = 32'h1 << m_cnt;
            if (m_cnt == 5'd31) m_busy = 1'b0;
            m_cnt = m_cnt + 5'd1;
        end else if (c) begin
            m_busy = 1'b1;
            m_cnt  = '0;
        end else if (v) begin
            m_q[a*16 +: 16] = d;
            e.strobe = 32'h1 << a;
        end
        e.q    = m_q;
        e.busy = m_busy;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 512'd0, 512'd1);
        end else begin
            got = sb.pop_front();
            check({got.tag, ".strobe"}, 512'(Strobe), 512'(got.strobe));
            check({got.tag, ".q"}, Q, got.q);
            check({got.tag, ".busy"}, 512'(Busy), 512'(got.busy));
        end
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        check({tag, ".q"}, Q, 512'd0);
        check({tag, ".strobe"}, 512'(Strobe), 512'd0);
        check({tag, ".busy"}, 512'(Busy), 512'd0);
        @(negedge Clk);
        ClrReq  = 1'b0;
        WrValid = 1'b0;
        Reset   = 1'b0;
        #1;
        check({tag, ".ready_after"}, 512'(WrReady), 512'd1);
    endtask

    initial begin
        Reset   = 1'b0;
        WrValid = 1'b0;
        WrAddr  = '0;
        WrData  = '0;
        ClrReq  = 1'b0;
        model_reset();

        // Reset asserted between edges must clear outputs immediately.
        #2;
        async_reset_check("por");

        cycle("single_w5", 1'b1, 5'd5, 16'hBEEF, 1'b0);
        cycle("single_idle", 1'b0, 5'd5, 16'h0000, 1'b0);

        cycle("b2b_a0", 1'b1, 5'd0, 16'h0001, 1'b0);
        cycle("b2b_a31", 1'b1, 5'd31, 16'hFFFF, 1'b0);
        cycle("b2b_a0_again", 1'b1, 5'd0, 16'h1234, 1'b0);
        cycle("b2b_idle", 1'b0, 5'd0, 16'h0000, 1'b0);
        check("b2b.word0", 512'(Q[15:0]), 512'(16'h1234));
        check("b2b.word31", 512'(Q[511:496]), 512'(16'hFFFF));

        // Full clear sweep with a bounded, counted busy window.
        cycle("pre_w3", 1'b1, 5'd3, 16'hAAAA, 1'b0);
        cycle("pre_w30", 1'b1, 5'd30, 16'h5555, 1'b0);
        cycle("clr_start", 1'b0, 5'd0, 16'h0000, 1'b1);
        busy_cycles = (Busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40 && m_busy; i++) begin
            cycle($sformatf("sweep%0d", i), 1'b0, 5'd0, 16'h0000, 1'b0);
            if (Busy === 1'b1) busy_cycles++;
        end
        check("sweep.busy_cycles", 512'(busy_cycles), 512'd32);
        check("sweep.all_zero", Q, 512'd0);
        cycle("sweep_done", 1'b0, 5'd0, 16'h0000, 1'b0);

        // Clear request colliding with a write; writes held during the sweep are ignored.
        cycle("col_pre_w7", 1'b1, 5'd7, 16'h2222, 1'b0);
        cycle("col_edge", 1'b1, 5'd7, 16'h1111, 1'b1);
        check("col.word7_kept", 512'(Q[127:112]), 512'(16'h2222));
        for (int i = 0; i < 40 && m_busy; i++) begin
            cycle($sformatf("col_sweep%0d", i), 1'b1, 5'd7, 16'h1111, 1'b0);
        end
        cycle("col_after", 1'b0, 5'd0, 16'h0000, 1'b0);
        check("col.all_zero", Q, 512'd0);

        // Reset while the sweep counter sits at 10.
        cycle("mid_pre_w20", 1'b1, 5'd20, 16'h7777, 1'b0);
        cycle("mid_clr", 1'b0, 5'd0, 16'h0000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle($sformatf("mid_sweep%0d", i), 1'b0, 5'd0, 16'h0000, 1'b0);
        end
        async_reset_check("mid_reset");
        cycle("post_w12", 1'b1, 5'd12, 16'h00FF, 1'b0);
        cycle("post_idle", 1'b0, 5'd0, 16'h0000, 1'b0);

        check("sb.drained", 512'(sb.size()), 512'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
